// File: rtl/sar_search_16b.sv
// sar_search_16b: successive-approximation search that recovers an unknown target
// by driving trial values into an external magnitude comparator and reading its flags.
module sar_search_16b #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_greater,
  input  logic             cmp_equal,
  input  logic             cmp_less,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       steps,
  output logic             flag_err
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d, trial_w, acc_nx;
  logic [IW-1:0]    idx_q, idx_d;
  logic [4:0]       steps_q, steps_d;
  logic             err_q, err_d, flags_ok;
  assign trial_w  = acc_q | (WIDTH'(1) << idx_q);
  assign flags_ok = $onehot({cmp_greater, cmp_equal, cmp_less});
  assign acc_nx   = cmp_less ? acc_q : trial_w;
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    steps_d  = steps_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (start) begin
        acc_d   = '0;
        idx_d   = IW'(WIDTH - 1);
        steps_d = '0;
        err_d   = 1'b0;
        state_d = SEARCH;
      end
      SEARCH: begin
        steps_d = steps_q + 5'd1;
        if (!flags_ok) begin
          err_d    = 1'b1;
          result_d = acc_q;
          state_d  = DONE;
        end else if (cmp_equal && EARLY_EXIT) begin
          result_d = trial_w;
          state_d  = DONE;
        end else begin
          acc_d    = acc_nx;
          idx_d    = idx_q - IW'(1);
          result_d = (idx_q == '0) ? acc_nx : result_q;
          state_d  = (idx_q == '0) ? DONE : SEARCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      steps_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      steps_q  <= steps_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end
  assign trial    = (state_q == SEARCH) ? trial_w : '0;
  assign busy     = state_q == SEARCH;
  assign done     = state_q == DONE;
  assign result   = result_q;
  assign steps    = steps_q;
  assign flag_err = err_q;
endmodule

// File: tb/tb_sar_search_16b.sv
// tb_sar_search_16b: scoreboard bench driving two searchers (early exit on/off)
// against a behavioural comparator, with directed and random targets.
module tb_sar_search_16b;
  logic clk = 0, rst_n = 0, start = 0, bad = 0;
  logic [15:0] tgt = 0;
  always #5 clk = ~clk;
  logic [15:0] trial1, trial0, result1, result0;
  logic busy1, busy0, done1, done0, err1, err0;
  logic [4:0] steps1, steps0;
  logic g1, e1, l1, g0, e0, l0;
  always_comb begin
    g1 = tgt > trial1;
    e1 = tgt == trial1;
    l1 = tgt < trial1;
    if (bad && trial1 == 16'hE000) begin
      g1 = 1'b0;
      e1 = 1'b1;
      l1 = 1'b1;
    end
  end
  assign g0 = tgt > trial0;
  assign e0 = tgt == trial0;
  assign l0 = tgt < trial0;
  sar_search_16b #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .cmp_greater(g1), .cmp_equal(e1),
    .cmp_less(l1), .trial(trial1), .busy(busy1), .done(done1), .result(result1),
    .steps(steps1), .flag_err(err1));
  sar_search_16b #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .cmp_greater(g0), .cmp_equal(e0),
    .cmp_less(l0), .trial(trial0), .busy(busy0), .done(done0), .result(result0),
    .steps(steps0), .flag_err(err0));
  typedef struct {logic [15:0] res; int st; bit err;} exp_t;
  exp_t q1[$], q0[$];
  logic [15:0] tr1[$];
  int tests = 0, fails = 0, cyc = 0, start_cyc = 0, nd1 = 0, nd0 = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  // searches finish when the trial hits the lowest set bit of the target
  function automatic int ee_steps(logic [15:0] t);
    for (int i = 0; i < 16; i++) if (t[i]) return 16 - i;
    return 16;
  endfunction
  always @(negedge clk) begin
    exp_t x;
    if (busy1) tr1.push_back(trial1);
    if (done1) begin
      nd1++;
      if (q1.size() == 0) chk("unexpected_done1", 1, 0);
      else begin
        x = q1.pop_front();
        chk("result1", result1, x.res);
        chk("steps1", steps1, x.st);
        chk("err1", err1, x.err);
        chk("latency1", cyc - start_cyc + 1, x.st + 2);
        chk("busy1_in_done", busy1, 0);
      end
    end
  end
  always @(negedge clk) begin
    exp_t x;
    if (done0) begin
      nd0++;
      if (q0.size() == 0) chk("unexpected_done0", 1, 0);
      else begin
        x = q0.pop_front();
        chk("result0", result0, x.res);
        chk("steps0", steps0, x.st);
        chk("err0", err0, x.err);
        chk("latency0", cyc - start_cyc + 1, x.st + 2);
      end
    end
  end
  task automatic run(logic [15:0] t, bit hold, bit forced, logic [15:0] xres, int xst);
    int a1, a0, k;
    tgt = t;
    bad = forced;
    tr1.delete();
    q1.push_back('{xres, xst, forced});
    q0.push_back('{t, 16, 1'b0});
    a1 = nd1;
    a0 = nd0;
    @(negedge clk);
    start = 1;
    start_cyc = cyc;
    if (!hold) begin
      @(negedge clk);
      start = 0;
    end
    for (k = 0; k < 40 && !(nd1 > a1 && nd0 > a0); k++) begin
      @(negedge clk);
      #1;
    end
    if (k == 40) chk("timeout", 1, 0);
    @(negedge clk);
    start = 0;
    bad = 0;
    @(negedge clk);
  endtask
  initial begin
    logic [15:0] r;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_trial", trial1, 0);
    chk("rst_result", result1, 0);
    chk("rst_steps", steps1, 0);
    chk("rst_err", err1, 0);
    rst_n = 1;
    run(16'h8000, 0, 0, 16'h8000, 1);
    chk("tr_8000_first", tr1.size() > 0 ? tr1[0] : 16'hxxxx, 16'h8000);
    chk("tr_8000_len", tr1.size(), 1);
    run(16'h0000, 0, 0, 16'h0000, 16);
    chk("tr_0000_len", tr1.size(), 16);
    for (int i = 0; i < 16 && i < tr1.size(); i++) chk("tr_0000", tr1[i], 16'h8000 >> i);
    run(16'hFFFF, 0, 0, 16'hFFFF, 16);
    run(16'hA5C3, 0, 0, 16'hA5C3, 16);
    if (tr1.size() >= 4) begin
      chk("tr_a5c3_0", tr1[0], 16'h8000);
      chk("tr_a5c3_1", tr1[1], 16'hC000);
      chk("tr_a5c3_2", tr1[2], 16'hA000);
      chk("tr_a5c3_3", tr1[3], 16'hB000);
    end else chk("tr_a5c3_len", tr1.size(), 16);
    run(16'hF000, 0, 1, 16'hC000, 3);
    chk("tr_bad_step3", tr1.size() >= 3 ? tr1[2] : 16'hxxxx, 16'hE000);
    run(16'h5A5B, 1, 0, 16'h5A5B, 16);
    repeat (3) @(negedge clk);
    chk("hold_idle_busy1", busy1, 0);
    chk("hold_idle_busy0", busy0, 0);
    tgt = 16'h1234;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    chk("mid_busy_before_rst", busy1, 1);
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_trial", trial1, 0);
    chk("mid_rst_done", done1, 0);
    chk("mid_rst_result", result1, 0);
    chk("mid_rst_steps", steps1, 0);
    chk("mid_rst_busy0", busy0, 0);
    rst_n = 1;
    repeat (20) @(negedge clk);
    chk("mid_rst_no_done", done1, 0);
    for (int n = 0; n < 1000; n++) begin
      r = 16'($urandom);
      run(r, 0, 0, r, ee_steps(r));
    end
    chk("q1_empty", q1.size(), 0);
    chk("q0_empty", q0.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
